// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_ctrl_pkg
// Description : Shared types and defaults for the register-file port controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_ctrl_pkg;

    localparam int c_def_addr_width = 4;
    localparam int c_def_data_width = 16;

    typedef logic [0:0] state_t;

    localparam state_t c_st_clear = 1'b0;
    localparam state_t c_st_run   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; search starts at the internal pointer,
//               which moves past the winner on every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NumReq   = 2,
    parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    input  logic [NumReq-1:0]   elig_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    logic [IdxWidth-1:0] r_ptr;
    logic [NumReq-1:0]   w_gnt;
    logic [IdxWidth-1:0] w_idx;
    logic                w_any;
    int                  w_cand;

    // Scan from the farthest offset down so the nearest eligible request wins.
    always_comb begin
        w_gnt  = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        w_cand = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NumReq) begin
                w_cand = w_cand - NumReq;
            end
            if (req_i[w_cand] && elig_i[w_cand]) begin
                w_any = 1'b1;
                w_idx = IdxWidth'(w_cand);
            end
        end
        w_gnt[w_idx] = w_any;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (int'(w_idx) == NumReq - 1) ? '0 : w_idx + IdxWidth'(1);
        end
    end

    assign gnt_o = w_gnt;
    assign idx_o = w_idx;
    assign any_o = w_any;

endmodule
`default_nettype wire

// File: rtl/register_file_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : register_file_port_ctrl
// Description : Shares a 1R/1W latch register file among NumReq requesters with
//               round-robin ports, RAW stalling and a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_port_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int AddrWidth = c_def_addr_width,
    parameter int DataWidth = c_def_data_width
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    output logic                        busy_o,
    input  logic [NumReq-1:0]           wreq_valid_i,
    output logic [NumReq-1:0]           wreq_ready_o,
    input  logic [NumReq*AddrWidth-1:0] wreq_addr_i,
    input  logic [NumReq*DataWidth-1:0] wreq_data_i,
    input  logic [NumReq-1:0]           rreq_valid_i,
    output logic [NumReq-1:0]           rreq_ready_o,
    input  logic [NumReq*AddrWidth-1:0] rreq_addr_i,
    output logic [NumReq-1:0]           rrsp_valid_o,
    output logic [DataWidth-1:0]        rrsp_data_o,
    output logic                        rf_we_o,
    output logic [AddrWidth-1:0]        rf_waddr_o,
    output logic [DataWidth-1:0]        rf_wdata_o,
    output logic [AddrWidth-1:0]        rf_raddr_o,
    input  logic [DataWidth-1:0]        rf_rdata_i
);

    localparam int c_idx_w = (NumReq > 1) ? $clog2(NumReq) : 1;

    state_t               r_state;
    logic [AddrWidth-1:0] r_cnt;
    logic                 r_haz_valid;
    logic [AddrWidth-1:0] r_haz_addr;

    logic                 w_run;
    logic [AddrWidth-1:0] w_waddr [NumReq];
    logic [DataWidth-1:0] w_wdata [NumReq];
    logic [AddrWidth-1:0] w_raddr [NumReq];
    logic [NumReq-1:0]    w_wreq;
    logic [NumReq-1:0]    w_rreq;
    logic [NumReq-1:0]    w_relig;
    logic [NumReq-1:0]    w_all_elig;
    logic [NumReq-1:0]    w_wgnt;
    logic [NumReq-1:0]    w_rgnt;
    logic [c_idx_w-1:0]   w_widx;
    logic [c_idx_w-1:0]   w_ridx;
    logic                 w_wany;
    logic                 w_rany;

    assign w_run      = (r_state == c_st_run);
    assign busy_o     = (r_state == c_st_clear);
    assign w_all_elig = '1;
    assign w_wreq     = wreq_valid_i & {NumReq{w_run}};
    assign w_rreq     = rreq_valid_i & {NumReq{w_run}};

    // A read of the address written last cycle would see the latch mid-update.
    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign w_waddr[i] = wreq_addr_i[i*AddrWidth +: AddrWidth];
        assign w_wdata[i] = wreq_data_i[i*DataWidth +: DataWidth];
        assign w_raddr[i] = rreq_addr_i[i*AddrWidth +: AddrWidth];
        assign w_relig[i] = !(r_haz_valid && (w_raddr[i] == r_haz_addr));
    end

    rr_arbiter #(.NumReq(NumReq), .IdxWidth(c_idx_w)) u_warb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (w_wreq),
        .elig_i (w_all_elig),
        .gnt_o  (w_wgnt),
        .idx_o  (w_widx),
        .any_o  (w_wany)
    );

    rr_arbiter #(.NumReq(NumReq), .IdxWidth(c_idx_w)) u_rarb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (w_rreq),
        .elig_i (w_relig),
        .gnt_o  (w_rgnt),
        .idx_o  (w_ridx),
        .any_o  (w_rany)
    );

    assign wreq_ready_o = w_wgnt;
    assign rreq_ready_o = w_rgnt;
    assign rf_we_o      = busy_o | w_wany;
    assign rf_waddr_o   = busy_o ? r_cnt : w_waddr[w_widx];
    assign rf_raddr_o   = w_raddr[w_ridx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_clear;
            r_cnt   <= '0;
        end else if (clear_i) begin
            r_state <= c_st_clear;
            r_cnt   <= '0;
        end else if (r_state == c_st_clear) begin
            if (r_cnt == '1) begin
                r_state <= c_st_run;
            end
            r_cnt <= r_cnt + AddrWidth'(1);
        end
    end

    // Write data is registered so it is stable while the latch is transparent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_wdata_o   <= '0;
            rrsp_valid_o <= '0;
            rrsp_data_o  <= '0;
            r_haz_valid  <= 1'b0;
            r_haz_addr   <= '0;
        end else begin
            if (busy_o) begin
                rf_wdata_o <= '0;
            end else if (w_wany) begin
                rf_wdata_o <= w_wdata[w_widx];
            end
            rrsp_valid_o <= w_rgnt;
            if (w_rany) begin
                rrsp_data_o <= rf_rdata_i;
            end
            r_haz_valid <= w_wany;
            if (w_wany) begin
                r_haz_addr <= rf_waddr_o;
            end
        end
    end

endmodule
`default_nettype wire
